sample_fifo: RTL and testbench

SAMPLE_FIFO -- requirements
Module: sample_fifo

---
 rtl/sample_fifo.sv | 50 +++++
 tb/tb_sample_fifo.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sample_fifo.sv
// sample_fifo: single-clock FIFO with registered read data, pop strobe and sticky overflow/underflow flags
module sample_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         d_in,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         d_out,
  output logic                     d_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
  assign pop   = rd_en && !empty;
  assign push  = wr_en && (!full || pop);
  always_ff @(posedge clk)
    if (push && !reset) mem[wr_ptr] <= d_in;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      d_out     <= '0;
      d_valid   <= 1'b0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        d_out  <= mem[rd_ptr];
      end
      d_valid   <= pop;
      count     <= (push && !pop) ? count + CW'(1) : (pop && !push) ? count - CW'(1) : count;
      overflow  <= overflow | (wr_en && !push);
      underflow <= underflow | (rd_en && empty);
    end
endmodule

// File: tb/tb_sample_fifo.sv
// tb_sample_fifo: directed stimulus with a scoreboard of hand-computed read values checked by a separate monitor
module tb_sample_fifo;
  logic       clk, reset, wr_en, rd_en, d_valid, empty, full, overflow, underflow;
  logic [2:0] d_in, d_out, count;
  int         total = 0, passed = 0;
  int         exp_q[$];

  sample_fifo #(.WIDTH(3), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .wr_en(wr_en), .rd_en(rd_en),
    .d_out(d_out), .d_valid(d_valid), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (d_valid) begin
      if (exp_q.size() == 0) chk("unexpected_d_valid", 1, 0);
      else chk("d_out", int'(d_out), exp_q.pop_front());
    end
  end

  task automatic step(input logic w, input logic r, input logic [2:0] d);
    wr_en = w; rd_en = r; d_in = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic pop_exp(input int v);
    exp_q.push_back(v);
    step(1'b0, 1'b1, 3'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_d_out"}, int'(d_out), 0);
    chk({tag, "_d_valid"}, int'(d_valid), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
    chk({tag, "_unf"}, int'(underflow), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1; d_in = 3'd7;
    @(posedge clk);
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; reset = 1'b0;
    chk_reset_state("rst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; d_in = '0;
    #1;
    chk_reset_state("por");
    do_reset();
    step(1, 0, 5); step(1, 0, 2); step(1, 0, 7);
    chk("t1_count3", int'(count), 3);
    pop_exp(5); pop_exp(2); pop_exp(7);
    chk("t1_count0", int'(count), 0);
    chk("t1_empty", int'(empty), 1);
    step(1, 0, 1); step(1, 0, 2); step(1, 0, 3); step(1, 0, 4);
    chk("t2_full", int'(full), 1);
    chk("t2_ovf_before", int'(overflow), 0);
    step(1, 0, 6);
    chk("t2_count", int'(count), 4);
    chk("t2_ovf", int'(overflow), 1);
    pop_exp(1); pop_exp(2); pop_exp(3); pop_exp(4);
    chk("t2_ovf_sticky", int'(overflow), 1);
    chk("t2_empty", int'(empty), 1);
    do_reset();
    step(1, 1, 3);
    chk("t3_unf", int'(underflow), 1);
    chk("t3_d_valid", int'(d_valid), 0);
    chk("t3_d_out", int'(d_out), 0);
    chk("t3_count", int'(count), 1);
    pop_exp(3);
    chk("t3_count0", int'(count), 0);
    chk("t3_unf_sticky", int'(underflow), 1);
    do_reset();
    step(1, 0, 1); step(1, 0, 2); step(1, 0, 3); step(1, 0, 4);
    exp_q.push_back(1);
    step(1, 1, 5);
    chk("t4_count", int'(count), 4);
    chk("t4_full", int'(full), 1);
    chk("t4_d_out", int'(d_out), 1);
    pop_exp(2); pop_exp(3); pop_exp(4); pop_exp(5);
    chk("t4_ovf", int'(overflow), 0);
    do_reset();
    step(1, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      exp_q.push_back((i - 1) % 8);
      step(1, 1, 3'(i % 8));
      if (i == 10) chk("t5_count_mid", int'(count), 1);
    end
    pop_exp(4);
    chk("t5_ovf", int'(overflow), 0);
    chk("t5_unf", int'(underflow), 0);
    chk("t5_empty", int'(empty), 1);
    do_reset();
    step(1, 0, 1); step(1, 0, 2); step(1, 0, 3); step(1, 0, 4); step(1, 0, 5);
    pop_exp(1);
    chk("t6_count3", int'(count), 3);
    chk("t6_ovf", int'(overflow), 1);
    #2 reset = 1'b1;
    #1 chk_reset_state("async");
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(1, 0, 4);
    pop_exp(4);
    chk("t6_count0", int'(count), 0);
    repeat (2) @(posedge clk);
    #2;
    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
